axis_dac_serial_multi: RTL and testbench

Parametrised multi-channel serial DAC driver for AD5791-class 20-bit DACs. It sits downstream of axis_spm_control and replaces the fixed 4-axis driver. It accepts N_CH AXI-stream-style data channels plus a raw configuration path. It shifts one 24-bit frame per channel in parallel on a shared SCLK/SYNC with one SDI line per channel. Per-channel configuration words are loaded by axis index and sent on a send strobe, matching the existing configuration_mode/axis/send software contract.

---
 rtl/dac_serial_pkg.sv | 25 ++
 rtl/dac_shift_lane.sv | 27 ++
 rtl/axis_dac_serial_multi.sv | 209 ++++++++++++++++++++
 tb/tb_axis_dac_serial_multi.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_serial_pkg.sv
// Shared constants, FSM state type and frame helper for the multi-channel AD5791 serial driver.
// Optional feature macro used by the top level: DAC_SKIP_UNCHANGED_EN.
package dac_serial_pkg;

    localparam int FRAME_W    = 24;
    localparam int DAC_DATA_W = 20;
    localparam int RW_BIT     = 23;
    localparam logic [2:0] DAC_REG_ADDR = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } dac_state_e;

    // Write (R/W=0) to the DAC data register with the given 20-bit code.
    function automatic logic [FRAME_W-1:0] data_frame(input logic [DAC_DATA_W-1:0] code);
        logic [FRAME_W-1:0] w;
        w = {1'b0, DAC_REG_ADDR, code};
        w[RW_BIT] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/dac_shift_lane.sv
// One SDI lane: 24-bit MSB-first shift register, parallel load, zero fill on shift.
module dac_shift_lane
    import dac_serial_pkg::*;
(
    input  logic               a_clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [FRAME_W-1:0] load_word,
    output logic               sdi
);

    logic [FRAME_W-1:0] sr;

    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_word;
        end else if (shift) begin
            sr <= {sr[FRAME_W-2:0], 1'b0};
        end
    end

    assign sdi = sr[FRAME_W-1];

endmodule

// File: rtl/axis_dac_serial_multi.sv
// N_CH-lane serial DAC driver with shared SCLK/SYNC, data streaming and config-frame modes.
// Optional macro DAC_SKIP_UNCHANGED_EN: suppress data frames when no channel code changed.
module axis_dac_serial_multi
    import dac_serial_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DATA_W   = 20,
    parameter int SCLK_DIV = 2,
    parameter int GAP_CYC  = 4
) (
    input  logic                a_clk,
    input  logic                reset,
    input  logic [32*N_CH-1:0]  S_AXIS_tdata,
    input  logic [N_CH-1:0]     S_AXIS_tvalid,
    input  logic [31:0]         S_AXISCFG_tdata,
    input  logic                S_AXISCFG_tvalid,
    input  logic                configuration_mode,
    input  logic [2:0]          configuration_axis,
    input  logic                configuration_send,
    output logic                dac_sclk,
    output logic                dac_sync_n,
    output logic [N_CH-1:0]     dac_sdi,
    output logic                busy,
    output logic [31:0]         frame_cnt
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [DAC_DATA_W-1:0] CODE_MASK = {DAC_DATA_W{1'b1}} << (DAC_DATA_W - DATA_W);

    logic [DAC_DATA_W-1:0] hold      [N_CH];
    logic [FRAME_W-1:0]    cfg       [N_CH];
    logic [FRAME_W-1:0]    load_word [N_CH];

    logic send_q, send_edge_q, cfg_pend;
    logic data_changed, launch, load_go, shift_en;

    dac_state_e       state, state_n;
    logic [DIV_W-1:0] div_cnt, div_cnt_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic [4:0]       bit_cnt, bit_cnt_n;
    logic             sclk_hi, sclk_hi_n;
    logic             div_last, gap_last, frame_done;
    logic             sclk_d, sync_n_d, busy_d;

    logic [N_CH-1:0] unused_lo;
    logic            unused_cfg_hi;

    for (genvar k = 0; k < N_CH; k++) begin : g_unused
        assign unused_lo[k] = ^S_AXIS_tdata[32*k +: 12];
    end
    assign unused_cfg_hi = ^S_AXISCFG_tdata[31:24];

    // Holding and config registers; latching continues regardless of FSM state.
    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                hold[k] <= '0;
                cfg[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (S_AXIS_tvalid[k]) begin
                    hold[k] <= S_AXIS_tdata[32*k+12 +: DAC_DATA_W] & CODE_MASK;
                end
                if (configuration_mode && S_AXISCFG_tvalid && configuration_axis == 3'(k)) begin
                    cfg[k] <= S_AXISCFG_tdata[FRAME_W-1:0];
                end
            end
        end
    end

    // A send edge arriving in the same cycle as the LOAD that clears the flag stays pending.
    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            send_q      <= 1'b0;
            send_edge_q <= 1'b0;
            cfg_pend    <= 1'b0;
        end else begin
            send_q      <= configuration_send;
            send_edge_q <= configuration_send & ~send_q;
            cfg_pend    <= (send_edge_q & configuration_mode) | (cfg_pend & ~load_go);
        end
    end

`ifdef DAC_SKIP_UNCHANGED_EN
    logic [DAC_DATA_W-1:0] last_sent [N_CH];

    always_comb begin
        data_changed = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (hold[k] != last_sent[k]) data_changed = 1'b1;
        end
    end

    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) last_sent[k] <= '0;
        end else if (load_go && !cfg_pend) begin
            for (int k = 0; k < N_CH; k++) last_sent[k] <= hold[k];
        end
    end
`else
    assign data_changed = 1'b1;
`endif

    assign launch = cfg_pend | (~configuration_mode & data_changed);

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            load_word[k] = cfg_pend ? cfg[k] : data_frame(hold[k]);
        end
    end

    assign div_last = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign gap_last = (gap_cnt == GAP_W'(GAP_CYC - 1));

    // Per bit: SCLK high for SCLK_DIV cycles, then low for SCLK_DIV cycles.
    always_comb begin
        state_n    = state;
        div_cnt_n  = div_cnt;
        gap_cnt_n  = gap_cnt;
        bit_cnt_n  = bit_cnt;
        sclk_hi_n  = sclk_hi;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (launch) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                state_n   = ST_SHIFT;
                div_cnt_n = '0;
                bit_cnt_n = '0;
                sclk_hi_n = 1'b1;
            end
            ST_SHIFT: begin
                if (!div_last) begin
                    div_cnt_n = div_cnt + 1'b1;
                end else begin
                    div_cnt_n = '0;
                    if (sclk_hi) begin
                        sclk_hi_n = 1'b0;
                    end else if (bit_cnt == 5'(FRAME_W - 1)) begin
                        state_n   = ST_GAP;
                        gap_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        sclk_hi_n = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (!gap_last) begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end else begin
                    frame_done = 1'b1;
                    state_n    = launch ? ST_LOAD : ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output values are looked ahead from the next state so the pins are plain flops.
    always_comb begin
        sclk_d   = (state_n == ST_SHIFT) && sclk_hi_n;
        sync_n_d = !((state_n == ST_LOAD) || (state_n == ST_SHIFT));
        busy_d   = (state_n != ST_IDLE);
    end

    assign load_go  = (state_n == ST_LOAD);
    assign shift_en = (state == ST_SHIFT) && sclk_hi && div_last;

    always_ff @(posedge a_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            sclk_hi    <= 1'b0;
            dac_sclk   <= 1'b0;
            dac_sync_n <= 1'b1;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_cnt_n;
            gap_cnt    <= gap_cnt_n;
            bit_cnt    <= bit_cnt_n;
            sclk_hi    <= sclk_hi_n;
            dac_sclk   <= sclk_d;
            dac_sync_n <= sync_n_d;
            busy       <= busy_d;
            if (frame_done) frame_cnt <= frame_cnt + 32'd1;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        dac_shift_lane u_lane (
            .a_clk     (a_clk),
            .reset     (reset),
            .load      (load_go),
            .shift     (shift_en),
            .load_word (load_word[k]),
            .sdi       (dac_sdi[k])
        );
    end

endmodule

// File: tb/tb_axis_dac_serial_multi.sv
// Bench for axis_dac_serial_multi: frame monitor, vector table, random data vs model, config/reset sequences.
module tb_axis_dac_serial_multi;

    localparam int N_CH    = 4;
    localparam int GAP_CYC = 4;
    localparam int SDIV    = 2;
    localparam int PERIOD  = 1 + 48*SDIV + GAP_CYC;

    logic               a_clk;
    logic               reset;
    logic [32*N_CH-1:0] s_tdata;
    logic [N_CH-1:0]    s_tvalid;
    logic [31:0]        cfg_tdata;
    logic               cfg_tvalid;
    logic               cfg_mode;
    logic [2:0]         cfg_axis;
    logic               cfg_send;
    logic               dac_sclk;
    logic               dac_sync_n;
    logic [N_CH-1:0]    dac_sdi;
    logic               busy;
    logic [31:0]        frame_cnt;

    axis_dac_serial_multi dut (
        .a_clk              (a_clk),
        .reset              (reset),
        .S_AXIS_tdata       (s_tdata),
        .S_AXIS_tvalid      (s_tvalid),
        .S_AXISCFG_tdata    (cfg_tdata),
        .S_AXISCFG_tvalid   (cfg_tvalid),
        .configuration_mode (cfg_mode),
        .configuration_axis (cfg_axis),
        .configuration_send (cfg_send),
        .dac_sclk           (dac_sclk),
        .dac_sync_n         (dac_sync_n),
        .dac_sdi            (dac_sdi),
        .busy               (busy),
        .frame_cnt          (frame_cnt)
    );

    typedef struct {
        logic [23:0] w [N_CH];
        int          nbits;
        int          t_fall;
        int          t_rise;
        int          first_rise;
        int          idx;
        logic [31:0] fc;
    } frame_t;

    typedef struct {
        logic [127:0] td;
        logic [3:0]   vld;
        logic [95:0]  exp;
    } vec_t;

    frame_t      cap_q [$];
    logic [23:0] exp_q [$];
    logic [31:0] m_hold [N_CH];
    vec_t        vecs [3];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          mon_done = 0;

    // Clock and cycle counter.
    initial begin
        a_clk = 1'b0;
        forever #5 a_clk = ~a_clk;
    end

    initial forever begin
        @(posedge a_clk);
        cyc = cyc + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Frame monitor: data is stable while SCLK is high, captured at each SCLK rise.
    initial begin
        frame_t cur;
        logic   prev_sync;
        logic   prev_sclk;
        prev_sync = 1'b1;
        prev_sclk = 1'b0;
        cur.nbits = 0;
        forever begin
            @(negedge a_clk);
            if (!dac_sync_n && prev_sync) begin
                cur.t_fall     = cyc;
                cur.nbits      = 0;
                cur.first_rise = -1;
                for (int k = 0; k < N_CH; k++) cur.w[k] = '0;
            end
            if (!dac_sync_n && dac_sclk && !prev_sclk) begin
                if (cur.nbits == 0) cur.first_rise = cyc;
                for (int k = 0; k < N_CH; k++) cur.w[k] = {cur.w[k][22:0], dac_sdi[k]};
                cur.nbits = cur.nbits + 1;
            end
            if (dac_sync_n && !prev_sync) begin
                cur.t_rise = cyc;
                cur.fc     = frame_cnt;
                cur.idx    = mon_done;
                cap_q.push_back(cur);
                if (cur.nbits == 24) mon_done = mon_done + 1;
            end
            if (reset) mon_done = 0;
            prev_sync = dac_sync_n;
            prev_sclk = dac_sclk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_max(input string name, input int act, input int bound);
        vectors = vectors + 1;
        if (act > bound || act < 0) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, expected 0..%0d", name, act, bound);
        end
    endtask

    function automatic logic [23:0] model_word(input logic [31:0] q31);
        return 24'h100000 | 24'(q31 >> 12);
    endfunction

    // Oldest captured frame whose SYNC fall is later than cycle 'after'.
    task automatic get_frame(input int after, output frame_t f);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 4*PERIOD) begin
            while (cap_q.size() > 0 && !got) begin
                f = cap_q.pop_front();
                if (f.t_fall > after) got = 1'b1;
            end
            if (!got) begin
                @(negedge a_clk);
                n = n + 1;
            end
        end
        if (!got) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL frame_timeout: no frame after cycle %0d, got none, expected one", after);
            for (int k = 0; k < N_CH; k++) f.w[k] = '0;
            f.nbits = 0; f.t_fall = 0; f.t_rise = 0; f.first_rise = 0; f.idx = 0; f.fc = '0;
        end
    endtask

    task automatic apply_data(input logic [127:0] td, input logic [3:0] vld, output int a);
        @(negedge a_clk);
        s_tdata  = td;
        s_tvalid = vld;
        for (int k = 0; k < N_CH; k++) if (vld[k]) m_hold[k] = td[32*k +: 32];
        @(negedge a_clk);
        a = cyc;
        s_tvalid = '0;
    endtask

    task automatic cfg_write(input logic [2:0] axis, input logic [31:0] data);
        @(negedge a_clk);
        cfg_axis   = axis;
        cfg_tdata  = data;
        cfg_tvalid = 1'b1;
        @(negedge a_clk);
        cfg_tvalid = 1'b0;
    endtask

    task automatic pulse_send(output int s);
        @(negedge a_clk);
        cfg_send = 1'b1;
        @(negedge a_clk);
        cfg_send = 1'b0;
        s = cyc;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge a_clk);
    endtask

    initial begin
        frame_t f, fa, fb;
        int a, s, r, n;
        string nm;

        vecs[0].td = {32'h80000000, 32'h0, 32'h0, 32'h7FFFF000};
        vecs[0].vld = 4'b1001;
        vecs[0].exp = {24'h180000, 24'h100000, 24'h100000, 24'h17FFFF};
        vecs[1].td = {32'hABCDE000, 32'h00001FFF, 32'hFFFFFFFF, 32'h12345678};
        vecs[1].vld = 4'b1111;
        vecs[1].exp = {24'h1ABCDE, 24'h100001, 24'h1FFFFF, 24'h112345};
        vecs[2].td = {32'h40000000, 32'h7FFFFFFF, 32'h80001000, 32'h00000FFF};
        vecs[2].vld = 4'b1111;
        vecs[2].exp = {24'h140000, 24'h17FFFF, 24'h180001, 24'h100000};

        reset = 1'b1;
        s_tdata = '0; s_tvalid = '0;
        cfg_tdata = '0; cfg_tvalid = 1'b0; cfg_mode = 1'b0; cfg_axis = '0; cfg_send = 1'b0;
        for (int k = 0; k < N_CH; k++) m_hold[k] = '0;

        wait_cycles(3);
        check("rst_sclk", 32'(dac_sclk), 32'd0);
        check("rst_sync_n", 32'(dac_sync_n), 32'd1);
        check("rst_sdi", 32'(dac_sdi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", frame_cnt, 32'd0);
        reset = 1'b0;
        r = cyc;

`ifdef DAC_SKIP_UNCHANGED_EN
        wait_cycles(2*PERIOD);
        check("skip_idle_frames", 32'(cap_q.size()), 32'd0);
        @(negedge a_clk);
        s_tdata = {4{32'h11111000}};
        s_tvalid = '1;
        wait_cycles(1000);
        s_tvalid = '0;
        for (int k = 0; k < N_CH; k++) m_hold[k] = 32'h11111000;
        check("skip_const_frames", 32'(cap_q.size()), 32'd1);
        cap_q.delete();
        apply_data({32'h0, 32'h0, 32'h22222000, 32'h0}, 4'b0010, a);
        wait_cycles(4*PERIOD);
        check("skip_change_frames", 32'(cap_q.size()), 32'd1);
        get_frame(a, f);
        check("skip_change_ch1", 32'(f.w[1]), 32'h122222);
        check("skip_change_ch0", 32'(f.w[0]), 32'h111111);
`else
        for (int i = 0; i < 3; i++) begin
            get_frame(r, f);
            r = f.t_fall;
            for (int k = 0; k < N_CH; k++) begin
                nm = $sformatf("idle_f%0d_ch%0d", i, k);
                check(nm, 32'(f.w[k]), 32'h100000);
            end
            check($sformatf("idle_f%0d_nbits", i), 32'(f.nbits), 32'd24);
            check($sformatf("idle_f%0d_frame_cnt", i), f.fc, 32'(f.idx));
            check($sformatf("idle_f%0d_sync_low", i), 32'(f.t_rise - f.t_fall), 32'(1 + 48*SDIV));
            check($sformatf("idle_f%0d_first_sclk", i), 32'(f.first_rise - f.t_fall), 32'd1);
            if (i == 1) fa = f;
            if (i == 2) check("idle_period", 32'(f.t_fall - fa.t_fall), 32'(PERIOD));
        end
`endif

        for (int i = 0; i < 3; i++) begin
            wait_cycles($urandom_range(0, PERIOD - 1));
            apply_data(vecs[i].td, vecs[i].vld, a);
            get_frame(a, f);
            for (int k = 0; k < N_CH; k++) begin
                check($sformatf("vec%0d_ch%0d", i, k), 32'(f.w[k]), 32'(vecs[i].exp[24*k +: 24]));
            end
            check_max($sformatf("vec%0d_latency", i), f.first_rise - (a - 1), PERIOD + 2);
        end

        for (int i = 0; i < 8; i++) begin
            logic [127:0] td;
            logic [3:0]   vld;
            td  = {$urandom, $urandom, $urandom, $urandom};
            vld = 4'($urandom_range(1, 15));
            wait_cycles($urandom_range(0, PERIOD - 1));
            apply_data(td, vld, a);
            for (int k = 0; k < N_CH; k++) exp_q.push_back(model_word(m_hold[k]));
            get_frame(a, f);
            for (int k = 0; k < N_CH; k++) begin
                check($sformatf("rand%0d_ch%0d", i, k), 32'(f.w[k]), 32'(exp_q.pop_front()));
            end
        end

        // Enter config mode mid-stream; the in-flight frame must still complete.
        @(negedge a_clk);
        cfg_mode = 1'b1;
        n = 0;
        while (busy && n < 2*PERIOD) begin
            @(negedge a_clk);
            n = n + 1;
        end
        check("mode_switch_idle", 32'(busy), 32'd0);
        if (cap_q.size() > 0) check("mode_switch_nbits", 32'(cap_q[$].nbits), 32'd24);
        cap_q.delete();
        cfg_write(3'd3, 32'd128);
        cfg_write(3'd2, 32'd64);
        cfg_write(3'd1, 32'd32);
        cfg_write(3'd0, 32'hFF000010);
        cfg_write(3'd4, 32'h00FFFFFF);
        wait_cycles(2*PERIOD);
        check("cfg_no_data_frames", 32'(cap_q.size()), 32'd0);

        pulse_send(s);
        get_frame(s - 2, f);
        check("cfg_ch3", 32'(f.w[3]), 32'h000080);
        check("cfg_ch2", 32'(f.w[2]), 32'h000040);
        check("cfg_ch1", 32'(f.w[1]), 32'h000020);
        check("cfg_ch0", 32'(f.w[0]), 32'h000010);
        check("cfg_frame_cnt", f.fc, 32'(f.idx));
        wait_cycles(3*PERIOD);
        check("cfg_single_frame", 32'(cap_q.size()), 32'd0);
        check("cfg_idle_sync", 32'(dac_sync_n), 32'd1);
        check("cfg_idle_busy", 32'(busy), 32'd0);

        // Second send and a config write while the first config frame is shifting.
        pulse_send(s);
        n = 0;
        while (!dac_sclk && n < PERIOD) begin
            @(negedge a_clk);
            n = n + 1;
        end
        cfg_write(3'd0, 32'h00000055);
        pulse_send(a);
        get_frame(s - 2, fa);
        get_frame(fa.t_fall, fb);
        check("cfg_a_ch0", 32'(fa.w[0]), 32'h000010);
        check("cfg_a_ch3", 32'(fa.w[3]), 32'h000080);
        check("cfg_b_ch0", 32'(fb.w[0]), 32'h000055);
        check("cfg_b_ch1", 32'(fb.w[1]), 32'h000020);
        check("cfg_b_start", 32'(fb.first_rise - fa.t_rise), 32'(GAP_CYC + 1));
        check("cfg_b_gap", 32'(fb.t_fall - fa.t_rise), 32'(GAP_CYC));
        wait_cycles(3*PERIOD);
        check("cfg_two_frames_only", 32'(cap_q.size()), 32'd0);

        // Back to streaming, then reset 30 cycles into a frame.
        @(negedge a_clk);
        cfg_mode = 1'b0;
        apply_data({32'h0, 32'h0, 32'h0, 32'h01234000}, 4'b0001, a);
        n = 0;
        while (dac_sync_n && n < 2*PERIOD) begin
            @(negedge a_clk);
            n = n + 1;
        end
        check("pre_reset_frame_started", 32'(dac_sync_n), 32'd0);
        repeat (30) @(posedge a_clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_sclk", 32'(dac_sclk), 32'd0);
        check("async_rst_sync_n", 32'(dac_sync_n), 32'd1);
        check("async_rst_sdi", 32'(dac_sdi), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_frame_cnt", frame_cnt, 32'd0);
        wait_cycles(2);
        cap_q.delete();
        reset = 1'b0;
        r = cyc;
`ifdef DAC_SKIP_UNCHANGED_EN
        wait_cycles(2*PERIOD);
        check("post_reset_no_frame", 32'(cap_q.size()), 32'd0);
`else
        get_frame(r - 1, f);
        check("post_reset_restart", 32'(f.t_fall - r), 32'd1);
        check("post_reset_nbits", 32'(f.nbits), 32'd24);
        check("post_reset_frame_cnt", f.fc, 32'd0);
        for (int k = 0; k < N_CH; k++) begin
            check($sformatf("post_reset_ch%0d", k), 32'(f.w[k]), 32'h100000);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
